// File: rtl/ser_pkg.sv
// Shared definitions for the serial feeder blocks: FSM state codes and
// counter sizing helper.
package ser_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter width able to hold the values 0..w inclusive.
  function automatic int clog2w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready into a one-word
// holding register and shifts them out one bit per bit_en tick.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             bit_en_i,
  output logic             x_out_o,
  output logic             x_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic [0:0]       state_o
);

  if (WIDTH < 2) begin : g_width_check
    $error("bit_serializer: WIDTH must be >= 2, got %0d", WIDTH);
  end

  localparam int              CW       = clog2w(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  // Handshake: a word transfers on a posedge where in_valid_i and in_ready_o
  // are both high; in_data_i must stay stable while in_valid_i waits for ready.
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             accept;
  logic             load;
  logic             hold_first, sh_first;
  logic [WIDTH-1:0] hold_rest, sh_rest;

  assign in_ready_o = rst & ~hold_full_q;
  assign accept     = in_valid_i & in_ready_o;

  // sh always holds the bits still to be sent, next one at the head end.
  assign hold_first = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
  assign sh_first   = MSB_FIRST ? sh_q[WIDTH-1]   : sh_q[0];
  assign hold_rest  = MSB_FIRST ? {hold_q[WIDTH-2:0], 1'b0} : {1'b0, hold_q[WIDTH-1:1]};
  assign sh_rest    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}   : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    x_out_d     = x_out_q;
    x_valid_d   = x_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    load        = 1'b0;

    if (bit_en_i) begin
      if (state_q == ST_IDLE) begin
        if (hold_full_q) begin
          load = 1'b1;
        end else begin
          x_out_d   = IDLE_BIT;
          x_valid_d = 1'b0;
          sof_d     = 1'b0;
          eof_d     = 1'b0;
        end
      end else if (cnt_q != CNT_LAST) begin
        x_out_d = sh_first;
        sh_d    = sh_rest;
        sof_d   = 1'b0;
        cnt_d   = cnt_q + CNT_ONE;
        eof_d   = ((cnt_q + CNT_ONE) == CNT_LAST);
      end else if (hold_full_q) begin
        // Back-to-back: next word starts straight after the last bit.
        load = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        x_out_d   = IDLE_BIT;
        x_valid_d = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        cnt_d     = '0;
      end
    end

    if (load) begin
      state_d     = ST_SHIFT;
      sh_d        = hold_rest;
      x_out_d     = hold_first;
      x_valid_d   = 1'b1;
      sof_d       = 1'b1;
      eof_d       = 1'b0;
      cnt_d       = CNT_ONE;
      hold_full_d = 1'b0;
    end

    // accept needs hold empty, so it never coincides with a load.
    if (accept) begin
      hold_d      = in_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      x_out_q     <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign x_out_o   = x_out_q;
  assign x_valid_o = x_valid_q;
  assign sof_o     = sof_q;
  assign eof_o     = eof_q;
  assign busy_o    = (state_q == ST_SHIFT) | hold_full_q;
  assign state_o   = state_q;

endmodule
